// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   EX-stage ALU covering the RV32I register/immediate ALU operations and,
//   optionally, the RV32M multiply/divide family. Base operations finish in one
//   cycle. Multiply and divide run iteratively, one radix-2 step per cycle, for
//   XLEN cycles. The stall logic holds the pipeline while oBusy is high.
//
// Ports
//   iCLK      clock, rising edge
//   iRST      asynchronous active-high reset
//   iStart    request, accepted while the unit is IDLE or DONE
//   iALUOp    00 ADD, 01 SUB, 10 R-type decode, 11 I-type decode
//   iFunct7   instruction[31:25]
//   iFunct3   instruction[14:12]
//   iA, iB    operands (rs1, rs2/immediate)
//   oBusy     high while an iterative operation is running
//   oDone     one-cycle pulse, oResult/oZero/oIllegal valid
//   oResult   registered result, held until the next oDone
//   oZero     oResult == 0
//   oIllegal  decode failure for the operation reported with oDone
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int EN_M = 1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [1:0]      iALUOp,
  input  logic [6:0]      iFunct7,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult,
  output logic            oZero,
  output logic            oIllegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [SHW-1:0] CNT_INIT = SHW'(XLEN - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_op = OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] base_alu(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_SUB:  base_alu = a - b;
      OP_SLL:  base_alu = a << sh;
      OP_SLT:  base_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: base_alu = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  base_alu = a ^ b;
      OP_SRL:  base_alu = a >> sh;
      OP_SRA:  base_alu = $signed(a) >>> sh;
      OP_OR:   base_alu = a | b;
      OP_AND:  base_alu = a & b;
      default: base_alu = a + b;
    endcase
  endfunction

  logic [1:0]      r_state;
  logic [SHW-1:0]  r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_ill;

  // Iterative datapath: r_hi/r_lo form the product (multiply) or the
  // remainder/quotient pair (divide); r_opb is the multiplicand or divisor.
  logic [2:0]      r_mop;
  logic            r_neg_a;
  logic            r_neg_b;
  logic            r_divz;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opb;

  logic [3:0]      w_op;
  logic            w_ill;
  logic            w_ism;
  logic            w_accept;
  logic [XLEN-1:0] w_base_res;

  always_comb begin
    w_op  = OP_ADD;
    w_ill = 1'b0;
    w_ism = 1'b0;
    case (iALUOp)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        if (iFunct7 == 7'b0000000) begin
          w_op = f3_op(iFunct3);
        end else if (iFunct7 == 7'b0100000) begin
          if (iFunct3 == 3'b000)      w_op  = OP_SUB;
          else if (iFunct3 == 3'b101) w_op  = OP_SRA;
          else                        w_ill = 1'b1;
        end else if (iFunct7 == 7'b0000001 && EN_M != 0) begin
          w_ism = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      default: begin
        // Immediate forms: funct7 only qualifies the shifts.
        w_op = f3_op(iFunct3);
        if (iFunct3 == 3'b001 && iFunct7 != 7'b0000000) w_ill = 1'b1;
        if (iFunct3 == 3'b101) begin
          if (iFunct7 == 7'b0100000)      w_op  = OP_SRA;
          else if (iFunct7 != 7'b0000000) w_ill = 1'b1;
        end
      end
    endcase
  end

  assign w_accept   = iStart && (r_state == S_IDLE || r_state == S_DONE);
  assign w_base_res = w_ill ? '0 : base_alu(w_op, iA, iB);

  // Operand signedness for the M ops: MULHU, DIVU, REMU treat both operands
  // as unsigned; MULHSU treats only B as unsigned.
  logic            w_sa;
  logic            w_sb;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;

  assign w_sa    = (iFunct3 != 3'b011) && (iFunct3 != 3'b101) && (iFunct3 != 3'b111);
  assign w_sb    = w_sa && (iFunct3 != 3'b010);
  assign w_neg_a = w_sa & iA[XLEN-1];
  assign w_neg_b = w_sb & iB[XLEN-1];
  assign w_mag_a = w_neg_a ? -iA : iA;
  assign w_mag_b = w_neg_b ? -iB : iB;

  logic [XLEN:0]     w_msum;
  logic [XLEN:0]     w_shrem;
  logic [XLEN:0]     w_dsub;
  logic              w_dge;
  logic [XLEN-1:0]   w_shi;
  logic [XLEN-1:0]   w_slo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic              w_negq;
  logic [XLEN-1:0]   w_mres;

  // Shift-add multiply: add multiplicand when the multiplier LSB is set,
  // then shift the {carry, hi, lo} product right by one.
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  // Restoring divide: shift next dividend bit into the remainder, subtract
  // the divisor when it fits, shift the quotient bit into r_lo.
  assign w_shrem = {r_hi, r_lo[XLEN-1]};
  assign w_dge   = w_shrem >= {1'b0, r_opb};
  assign w_dsub  = w_shrem - {1'b0, r_opb};

  always_comb begin
    if (r_mop[2]) begin
      w_shi = w_dge ? w_dsub[XLEN-1:0] : w_shrem[XLEN-1:0];
      w_slo = {r_lo[XLEN-2:0], w_dge};
    end else begin
      w_shi = w_msum[XLEN:1];
      w_slo = {w_msum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign correction applied to the outcome of the final step.
  assign w_negq   = r_neg_a ^ r_neg_b;
  assign w_prod   = {w_shi, w_slo};
  assign w_prod_s = w_negq ? -w_prod : w_prod;

  always_comb begin
    case (r_mop)
      3'b000:          w_mres = w_prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          w_mres = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:  w_mres = r_divz ? '1  : (w_negq  ? -w_slo : w_slo);
      default:         w_mres = r_divz ? r_a : (r_neg_a ? -w_shi : w_shi);
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ill    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_mres;
            r_zero   <= (w_mres == '0);
            r_ill    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          if (iStart) begin
            if (w_ism) begin
              r_state <= S_RUN;
              r_cnt   <= CNT_INIT;
              r_busy  <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_base_res;
              r_zero   <= (w_base_res == '0);
              r_ill    <= w_ill;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_accept) begin
      r_mop   <= iFunct3;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_divz  <= (iB == '0);
      r_a     <= iA;
      r_hi    <= '0;
      if (iFunct3[2]) begin
        r_lo  <= w_mag_a;
        r_opb <= w_mag_b;
      end else begin
        r_lo  <= w_mag_b;
        r_opb <= w_mag_a;
      end
    end else if (r_state == S_RUN) begin
      r_hi <= w_shi;
      r_lo <= w_slo;
    end
  end

  assign oBusy    = r_busy;
  assign oDone    = r_done;
  assign oResult  = r_result;
  assign oZero    = r_zero;
  assign oIllegal = r_ill;

endmodule
